// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the per-bit datapath of serial_adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, WIDTH cycles per add,
// valid/ready handshakes on both operand and result sides.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             fa_s, fa_cout;

   full_adder u_full_adder (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (c_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      c_d      = c_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_sr_d  = a;
               b_sr_d  = b;
               c_d     = 1'b0;
               cnt_d   = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            c_d      = fa_cout;
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
            // Clear rather than increment on the last bit so cnt never passes WIDTH-1.
            if (cnt_q == LAST_BIT) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         c_q      <= c_d;
         cnt_q    <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign sum       = sum_sr_q;
   assign carry     = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder at WIDTH=8.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry;

   int n_vec  = 0;
   int n_fail = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_sum;
      logic         exp_carry;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept operands, scramble inputs while busy, and count edges until out_valid.
   task automatic start_and_wait(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 output int cycles);
      a_i       = va;
      b_i       = vb;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      check("in_ready before accept", 32'(in_ready), 32'd1);
      tick();
      cycles = 0;
      do begin
         a_i      = W'($urandom);
         b_i      = W'($urandom);
         in_valid = 1'($urandom);
         tick();
         cycles++;
      end while (!out_valid && cycles < 30);
      in_valid = 1'b0;
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid after accept"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready after accept"}, 32'(in_ready), 32'd1);
   endtask

   vec_t vecs[7];

   initial begin
      int cyc;
      int cycle_no;
      int acc_cnt;
      int res_cnt;
      int acc_at[2];
      logic [W-1:0] res_sum[2];
      logic         res_carry[2];
      logic         acc_now;
      logic         xfer_now;
      logic         saw_valid;

      vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[5] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 8'h00, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_i       = '0;
      b_i       = '0;
      tick();
      tick();
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset sum", 32'(sum), 32'd0);
      check("reset carry", 32'(carry), 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready after reset", 32'(in_ready), 32'd1);

      foreach (vecs[i]) begin
         start_and_wait(vecs[i].a, vecs[i].b, cyc);
         check($sformatf("vec%0d latency", i), 32'(cyc), 32'(W));
         check($sformatf("vec%0d sum", i), 32'(sum), 32'(vecs[i].exp_sum));
         check($sformatf("vec%0d carry", i), 32'(carry), 32'(vecs[i].exp_carry));
         finish_op($sformatf("vec%0d", i));
         check($sformatf("vec%0d sum held in idle", i), 32'(sum), 32'(vecs[i].exp_sum));
      end

      // Backpressure: result held while new operands are offered.
      start_and_wait(8'h12, 8'h34, cyc);
      check("bp latency", 32'(cyc), 32'(W));
      for (int k = 0; k < 5; k++) begin
         a_i      = W'($urandom);
         b_i      = W'($urandom);
         in_valid = 1'b1;
         tick();
         check($sformatf("bp%0d sum", k), 32'(sum), 32'h46);
         check($sformatf("bp%0d carry", k), 32'(carry), 32'd0);
         check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      finish_op("bp");

      // Reset while cnt==3 of 0xAA+0x55.
      a_i      = 8'hAA;
      b_i      = 8'h55;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst in_ready during rst", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst sum", 32'(sum), 32'd0);
      check("midrst carry", 32'(carry), 32'd0);
      saw_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         saw_valid |= out_valid;
      end
      check("midrst no out_valid", 32'(saw_valid), 32'd0);
      start_and_wait(8'h10, 8'h20, cyc);
      check("post-rst latency", 32'(cyc), 32'(W));
      check("post-rst sum", 32'(sum), 32'h30);
      check("post-rst carry", 32'(carry), 32'd0);
      finish_op("post-rst");

      // Back-to-back with in_valid and out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a_i       = 8'h01;
      b_i       = 8'h01;
      acc_cnt   = 0;
      res_cnt   = 0;
      cycle_no  = 0;
      while (res_cnt < 2 && cycle_no < 60) begin
         acc_now  = in_valid && in_ready;
         xfer_now = out_valid && out_ready;
         if (xfer_now) begin
            res_sum[res_cnt]   = sum;
            res_carry[res_cnt] = carry;
         end
         tick();
         cycle_no++;
         if (xfer_now) res_cnt++;
         if (acc_now) begin
            acc_at[acc_cnt] = cycle_no;
            acc_cnt++;
            if (acc_cnt == 1) begin
               a_i = 8'h80;
               b_i = 8'h80;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("b2b results seen", 32'(res_cnt), 32'd2);
      check("b2b accepts seen", 32'(acc_cnt), 32'd2);
      if (acc_cnt == 2) check("b2b accept spacing", 32'(acc_at[1] - acc_at[0]), 32'(W + 2));
      if (res_cnt == 2) begin
         check("b2b r0 sum", 32'(res_sum[0]), 32'h02);
         check("b2b r0 carry", 32'(res_carry[0]), 32'd0);
         check("b2b r1 sum", 32'(res_sum[1]), 32'h00);
         check("b2b r1 carry", 32'(res_carry[1]), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first adder that accepts two WIDTH-bit operands over a valid/ready handshake and returns their sum and carry-out. It is the addition counterpart to the team's combinational half subtractor (diff = a^b, borrow = ~a&b). It trades one full-adder cell plus shift registers for multi-cycle latency. It sits in the arithmetic datapath wherever area matters more than throughput.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  operands on a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  first operand (augend).
- b  input  WIDTH  second operand (addend).
- out_valid  output  1  sum/carry are valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b) mod 2^WIDTH.
- carry  output  1  carry-out of bit WIDTH-1.

## Operation
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: load a_sr<=a, b_sr<=b, carry reg c<=0, bit counter cnt<=0. Go to ADD.
- ADD:
  - Once per cycle: s = a_sr[0]^b_sr[0]^c; c <= majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by 1.
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}, i.e. shift right and insert s at the MSB.
  - cnt <= cnt+1.
  - The cycle with cnt==WIDTH-1 processes the last bit and goes to DONE.
- DONE:
  - out_valid=1; sum=sum_sr; carry=c. Both are held stable until accepted.
  - When out_ready: go to IDLE.
- in_ready = (state==IDLE) && !rst. It is combinational from state, with no dependence on out_ready.
- in_valid is ignored outside IDLE. The operand ports are sampled only on the acceptance edge; later changes to a/b have no effect.
- out_valid = (state==DONE). Once asserted, it stays high and sum/carry do not change until out_ready is sampled high.
- sum and carry show their registered values in every state. They hold the last result until the next one overwrites them; only out_valid qualifies them.
- Counter width is $clog2(WIDTH). cnt never exceeds WIDTH-1.
- Arithmetic is unsigned. The result sum and carry together form a WIDTH+1-bit value equal to a+b. Overflow is reported only through carry.

## Timing
- Reset, rst high at an edge:
  - State goes to IDLE; c, cnt, a_sr, b_sr, sum_sr go to 0.
  - The cycle after reset: out_valid=0, sum=0, carry=0.
  - in_ready=0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-ADD or mid-DONE aborts the operation. The partial result is discarded and no out_valid is produced.
- Latency: operands accepted at edge T. out_valid is high in the cycle following edge T+WIDTH (WIDTH ADD cycles).
- Throughput with out_ready held high: one operation per WIDTH+2 cycles (1 IDLE, WIDTH ADD, 1 DONE).
- Input transfer occurs on an edge where in_valid&&in_ready. Output transfer occurs on an edge where out_valid&&out_ready.
- out_ready high while out_valid is low has no effect.

## Structure
- Shared package serial_adder_pkg:
  - state enum {IDLE, ADD, DONE}, 2 bits.
  - DEFAULT_WIDTH=8 constant.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout), purely combinational, instantiated once for the per-bit sum/carry. It is the natural pairing with the existing half subtractor cell.
- Top-level contents: FSM, counter, shift registers, carry flop.

## Test plan
All scenarios use WIDTH=8.
- Basic add: a=0x5A, b=0x33 -> sum=0x8D, carry=0, with out_valid high in the cycle following the 8th edge after acceptance.
- Carry ripple and overflow: a=0xFF, b=0x01 -> sum=0x00, carry=1. Then a=0xFF, b=0xFF -> sum=0xFE, carry=1.
- Backpressure: complete a=0x12+b=0x34, hold out_ready=0 for 5 cycles and drive in_valid=1 with new operands throughout -> sum stays 0x46, carry=0, out_valid stays 1, in_ready stays 0; on out_ready=1 it returns to IDLE.
- Reset mid-operation: assert rst for one cycle when cnt==3 of a=0xAA+b=0x55 -> no out_valid; the next cycle has out_valid=0, sum=0, carry=0. Then a=0x10, b=0x20 -> sum=0x30, carry=0.
- Back-to-back: with in_valid and out_ready held high, issue 0x01+0x01 then 0x80+0x80 -> results 0x02/carry 0, then 0x00/carry 1. Acceptance edges are exactly 10 cycles apart.
- Input isolation: change a/b every cycle during ADD -> result depends only on the values present at the acceptance edge.
